// File: rtl/srt_div_pkg.sv
// srt_div_pkg: shared types and constants for the SRT divider scheduler.
// Holds the FSM encoding, default widths and the divide-by-zero quotient.
package srt_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DZ,
        RESP
    } state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_W       = 64;
    localparam int DEF_IDW     = 2;
    localparam int DEF_TIMEOUT = 255;

    // Widest datapath supported; users slice the low W bits.
    localparam int MAX_W = 256;
    localparam logic [MAX_W-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over N requesters.
// Searches upward from ptr_i, wrapping, and returns one-hot and index.
module rr_arbiter
    import srt_div_pkg::*;
#(
    parameter int N  = DEF_NREQ,
    parameter int IW = DEF_IDW
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] kk;

    // First set request at or above the pointer, modulo N.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        kk    = '0;
        for (int i = 0; i < N; i++) begin
            kk = IW'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[kk]) begin
                any_o     = 1'b1;
                gnt_o[kk] = 1'b1;
                idx_o     = kk;
            end
        end
    end

endmodule

// File: rtl/srt_div_sched.sv
// srt_div_sched: shares one SRT divider core between NREQ requesters.
// Round-robin grant, operand latch, start/done handshake, timeout abort.
module srt_div_sched
    import srt_div_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int IDW     = DEF_IDW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_dvd,
    input  logic [NREQ*W-1:0] req_dsr,
    output logic [NREQ-1:0]   gnt,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_q,
    output logic [W-1:0]      resp_r,
    output logic              resp_dz,
    output logic              resp_to,
    output logic              busy,
    output logic              div_start,
    output logic [W-1:0]      div_dvd,
    output logic [W-1:0]      div_dsr,
    input  logic              div_done,
    input  logic [W-1:0]      div_q,
    input  logic [W-1:0]      div_r
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  QALL   = DZ_QUOT[W-1:0];
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [W-1:0]    dvd_q;
    logic [W-1:0]    dsr_q;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  rid_q;
    logic [W-1:0]    rq_q;
    logic [W-1:0]    rr_q;
    logic            rdz_q;
    logic            rto_q;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            arb_any;
    logic [W-1:0]    sel_dvd;
    logic [W-1:0]    sel_dsr;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Pick the winner's operand slices.
    always_comb begin
        sel_dvd = '0;
        sel_dsr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IDW'(i)) begin
                sel_dvd = req_dvd[i*W +: W];
                sel_dsr = req_dsr[i*W +: W];
            end
        end
    end

    assign cnt_d = cnt_q + 1'b1;
    assign ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

    // Scheduler FSM with operand latches, timeout counter and result regs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            id_q    <= '0;
            rid_q   <= '0;
            rq_q    <= '0;
            rr_q    <= '0;
            rdz_q   <= 1'b0;
            rto_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        dvd_q   <= sel_dvd;
                        dsr_q   <= sel_dsr;
                        id_q    <= arb_idx;
                        state_q <= (sel_dsr == '0) ? DZ : ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (div_done) begin
                        rid_q   <= id_q;
                        rq_q    <= div_q;
                        rr_q    <= div_r;
                        rdz_q   <= 1'b0;
                        rto_q   <= 1'b0;
                        state_q <= RESP;
                    end else if (cnt_d == TO_LIM) begin
                        rid_q   <= id_q;
                        rq_q    <= '0;
                        rr_q    <= '0;
                        rdz_q   <= 1'b0;
                        rto_q   <= 1'b1;
                        state_q <= RESP;
                    end
                end
                DZ: begin
                    rid_q   <= id_q;
                    rq_q    <= QALL;
                    rr_q    <= dvd_q;
                    rdz_q   <= 1'b1;
                    rto_q   <= 1'b0;
                    state_q <= RESP;
                end
                RESP: begin
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt        = (state_q == IDLE && !RST) ? arb_gnt : '0;
    assign busy       = (state_q != IDLE);
    assign div_start  = (state_q == ISSUE);
    assign resp_valid = (state_q == RESP);
    assign resp_id    = rid_q;
    assign resp_q     = rq_q;
    assign resp_r     = rr_q;
    assign resp_dz    = rdz_q;
    assign resp_to    = rto_q;
    assign div_dvd    = dvd_q;
    assign div_dsr    = dsr_q;

endmodule

// File: tb/tb_srt_div_sched.sv
// tb_srt_div_sched: directed and random checks of the divider scheduler.
// A latency-programmable core model answers div_start with a/b and a%b.
module tb_srt_div_sched;

    localparam int NREQ = 4;
    localparam int W    = 64;
    localparam int IDW  = 2;
    localparam int TMO  = 15;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_dvd;
    logic [NREQ*W-1:0] req_dsr;
    logic [NREQ-1:0]   gnt;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_q;
    logic [W-1:0]      resp_r;
    logic              resp_dz;
    logic              resp_to;
    logic              busy;
    logic              div_start;
    logic [W-1:0]      div_dvd;
    logic [W-1:0]      div_dsr;
    logic              div_done;
    logic [W-1:0]      div_q;
    logic [W-1:0]      div_r;

    srt_div_sched #(
        .NREQ    (NREQ),
        .W       (W),
        .IDW     (IDW),
        .TIMEOUT (TMO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_dvd    (req_dvd),
        .req_dsr    (req_dsr),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_q     (resp_q),
        .resp_r     (resp_r),
        .resp_dz    (resp_dz),
        .resp_to    (resp_to),
        .busy       (busy),
        .div_start  (div_start),
        .div_dvd    (div_dvd),
        .div_dsr    (div_dsr),
        .div_done   (div_done),
        .div_q      (div_q),
        .div_r      (div_r)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mptr   = 0;

    int          core_lat  = 1;
    int          core_cd   = 0;
    bit          core_dead = 1'b0;
    bit          core_pend = 1'b0;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;

    int              ob_cyc;
    logic [NREQ-1:0] ob_gnt;
    logic            ob_rv;
    logic [IDW-1:0]  ob_id;
    logic [W-1:0]    ob_q;
    logic [W-1:0]    ob_r;
    logic            ob_dz;
    logic            ob_to;
    logic            ob_busy;
    logic            ob_start;
    logic [W-1:0]    ob_ddvd;
    logic [W-1:0]    ob_ddsr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe mid-cycle, then advance and drive the core model.
    task automatic step();
        @(negedge CLK);
        ob_cyc   = cyc;
        ob_gnt   = gnt;
        ob_rv    = resp_valid;
        ob_id    = resp_id;
        ob_q     = resp_q;
        ob_r     = resp_r;
        ob_dz    = resp_dz;
        ob_to    = resp_to;
        ob_busy  = busy;
        ob_start = div_start;
        ob_ddvd  = div_dvd;
        ob_ddsr  = div_dsr;
        if (div_start && !core_dead) begin
            core_pend = 1'b1;
            core_cd   = core_lat;
            core_a    = div_dvd;
            core_b    = div_dsr;
        end
        @(posedge CLK);
        #1;
        cyc++;
        div_done = 1'b0;
        if (core_pend) begin
            core_cd--;
            if (core_cd == 0) begin
                core_pend = 1'b0;
                div_done  = 1'b1;
                div_q     = (core_b != 0) ? core_a / core_b : '0;
                div_r     = (core_b != 0) ? core_a % core_b : '0;
            end
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int i = 0; i < NREQ; i++)
            if (m[(p + i) % NREQ]) return (p + i) % NREQ;
        return 0;
    endfunction

    // One transaction: grant the model's winner, wait for its response.
    task automatic serve(input int l, input bit dead, output int w);
        logic [W-1:0] a, b, eq, er;
        logic edz, eto;
        int g, s, rc, extra;
        w   = pick(req, mptr);
        a   = req_dvd[w*W +: W];
        b   = req_dsr[w*W +: W];
        edz = (b == 0);
        eto = !edz && dead;
        if (edz) begin
            eq = '1;
            er = a;
        end else if (eto) begin
            eq = '0;
            er = '0;
        end else begin
            eq = a / b;
            er = a % b;
        end
        core_lat  = l;
        core_dead = dead;
        step();
        g = ob_cyc;
        chk("gnt", 64'(ob_gnt), 64'(NREQ'(1) << w));
        req[w] = 1'b0;
        s = -1;
        rc = -1;
        extra = 0;
        for (int n = 0; n < TMO + 40 && rc < 0; n++) begin
            step();
            if (ob_start && s < 0) s = ob_cyc;
            if (ob_gnt != 0) extra++;
            if (ob_rv) rc = ob_cyc;
        end
        chk("resp_seen", 64'(rc >= 0), 64'(1));
        chk("resp_id", 64'(ob_id), 64'(w));
        chk("resp_q", ob_q, eq);
        chk("resp_r", ob_r, er);
        chk("resp_dz", 64'(ob_dz), 64'(edz));
        chk("resp_to", 64'(ob_to), 64'(eto));
        chk("no_gnt_busy", 64'(extra), 64'(0));
        if (edz) begin
            chk("dz_lat", 64'(rc - g), 64'(2));
            chk("dz_nostart", 64'(s < 0), 64'(1));
        end else begin
            chk("start_lat", 64'(s - g), 64'(1));
            if (eto)
                chk("to_lat", 64'((rc - g) >= TMO + 1 && (rc - g) <= TMO + 3),
                    64'(1));
            else
                chk("resp_lat", 64'(rc - s), 64'(l + 1));
        end
        mptr = (w + 1) % NREQ;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int acc_rv;
        int acc_busy;
        RST      = 1'b1;
        req      = '0;
        req_dvd  = '0;
        req_dsr  = '0;
        div_done = 1'b0;
        div_q    = '0;
        div_r    = '0;
        repeat (3) step();
        RST = 1'b0;
        step();
        chk("rst_gnt", 64'(ob_gnt), 64'(0));
        chk("rst_rv", 64'(ob_rv), 64'(0));
        chk("rst_id", 64'(ob_id), 64'(0));
        chk("rst_q", ob_q, 64'(0));
        chk("rst_r", ob_r, 64'(0));
        chk("rst_dz", 64'(ob_dz), 64'(0));
        chk("rst_to", 64'(ob_to), 64'(0));
        chk("rst_busy", 64'(ob_busy), 64'(0));
        chk("rst_start", 64'(ob_start), 64'(0));
        chk("rst_ddvd", ob_ddvd, 64'(0));
        chk("rst_ddsr", ob_ddsr, 64'(0));

        // Single request, core latency 5.
        req_dvd[0*W +: W] = 64'd74;
        req_dsr[0*W +: W] = 64'd21;
        req = 4'b0001;
        serve(5, 1'b0, w);
        chk("single_id", 64'(w), 64'(0));
        step();
        chk("hold_rv", 64'(ob_rv), 64'(0));
        chk("hold_q", ob_q, 64'd3);
        chk("hold_r", ob_r, 64'd11);

        // Contention between requesters 1 and 2, then again after wrap.
        req_dvd[1*W +: W] = 64'd100;
        req_dsr[1*W +: W] = 64'd7;
        req_dvd[2*W +: W] = 64'd9;
        req_dsr[2*W +: W] = 64'd3;
        req = 4'b0110;
        serve(3, 1'b0, w);
        chk("cont_first", 64'(w), 64'(1));
        serve(2, 1'b0, w);
        chk("cont_second", 64'(w), 64'(2));
        req = 4'b0110;
        serve(4, 1'b0, w);
        chk("wrap_first", 64'(w), 64'(1));
        serve(1, 1'b0, w);
        chk("wrap_second", 64'(w), 64'(2));

        // Divide by zero.
        req_dvd[3*W +: W] = 64'd55;
        req_dsr[3*W +: W] = 64'd0;
        req = 4'b1000;
        serve(1, 1'b0, w);

        // Timeout, then normal service with done on the limit cycle.
        req_dvd[0*W +: W] = 64'd999;
        req_dsr[0*W +: W] = 64'd5;
        req = 4'b0001;
        serve(1, 1'b1, w);
        req_dvd[1*W +: W] = 64'd1000;
        req_dsr[1*W +: W] = 64'd7;
        req = 4'b0010;
        serve(TMO, 1'b0, w);

        // Reset in the third WAIT cycle; a late done must be ignored.
        req_dvd[2*W +: W] = 64'd1000;
        req_dsr[2*W +: W] = 64'd10;
        core_dead = 1'b1;
        req = 4'b0100;
        step();
        chk("rw_gnt", 64'(ob_gnt), 64'(4'b0100));
        req = '0;
        step();
        chk("rw_start", 64'(ob_start), 64'(1));
        step();
        step();
        RST = 1'b1;
        step();
        chk("rw_wait_busy", 64'(ob_busy), 64'(1));
        RST = 1'b0;
        step();
        mptr = 0;
        core_pend = 1'b0;
        chk("rw_busy", 64'(ob_busy), 64'(0));
        chk("rw_rv", 64'(ob_rv), 64'(0));
        chk("rw_start0", 64'(ob_start), 64'(0));
        chk("rw_ddvd", ob_ddvd, 64'(0));
        chk("rw_ddsr", ob_ddsr, 64'(0));
        chk("rw_q", ob_q, 64'(0));
        step();
        div_done = 1'b1;
        div_q = 64'd123;
        div_r = 64'd4;
        acc_rv = 0;
        acc_busy = 0;
        repeat (6) begin
            step();
            acc_rv += int'(ob_rv);
            acc_busy += int'(ob_busy);
        end
        chk("late_done_rv", 64'(acc_rv), 64'(0));
        chk("late_done_busy", 64'(acc_busy), 64'(0));

        // Spurious done in IDLE.
        div_done = 1'b1;
        acc_rv = 0;
        acc_busy = 0;
        repeat (4) begin
            step();
            acc_rv += int'(ob_rv);
            acc_busy += int'(ob_busy);
        end
        chk("spur_rv", 64'(acc_rv), 64'(0));
        chk("spur_busy", 64'(acc_busy), 64'(0));

        // Fairness: all requesters asserted from pointer 0.
        for (int i = 0; i < NREQ; i++) begin
            req_dvd[i*W +: W] = 64'(1000 + 17 * i);
            req_dsr[i*W +: W] = 64'(3 + i);
        end
        req = '1;
        for (int i = 0; i < NREQ; i++) begin
            serve(2, 1'b0, w);
            chk("rotate", 64'(w), 64'(i));
        end

        // Random masks, operands and core latencies.
        for (int k = 0; k < 30; k++) begin
            logic [NREQ-1:0] m;
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if (m[i]) begin
                    req_dvd[i*W +: W] = {$urandom, $urandom};
                    if ($urandom_range(0, 7) == 0)
                        req_dsr[i*W +: W] = '0;
                    else
                        req_dsr[i*W +: W] =
                            {$urandom, $urandom} >> $urandom_range(0, 63);
                end
            end
            req = m;
            while (req != 0)
                serve(int'($urandom_range(1, 6)),
                      ($urandom_range(0, 11) == 0), w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/srt_div_sched.md
Name: srt_div_sched

Overview:
- Round-robin scheduler that shares one SRT divider core between NREQ requesters.
- Captures the winning requester's dividend and divisor, then sequences one division through a start/done handshake.
- Returns quotient, remainder, requester ID and status in a single-cycle response.
- Handles divide-by-zero without using the core, and times out if the core never answers.

Parameters:
- NREQ, 4, number of requesters (>=2).
- W, 64, operand/result width.
- IDW, 2, requester ID width; must equal clog2(NREQ).
- TIMEOUT, 255, maximum cycles spent in WAIT before abort.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request, level.
- req_dvd  in  NREQ*W  packed dividends; slice i belongs to requester i.
- req_dsr  in  NREQ*W  packed divisors.
- gnt  out  NREQ  one-hot grant, 1-cycle pulse.
- resp_valid  out  1  result strobe, 1-cycle pulse.
- resp_id  out  IDW  requester that owns the result.
- resp_q  out  W  quotient.
- resp_r  out  W  remainder.
- resp_dz  out  1  divide-by-zero flag.
- resp_to  out  1  timeout flag.
- busy  out  1  high in any state other than IDLE.
- div_start  out  1  core start pulse.
- div_dvd  out  W  core dividend.
- div_dsr  out  W  core divisor.
- div_done  in  1  core completion pulse.
- div_q  in  W  core quotient.
- div_r  in  W  core remainder.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, timeout counter=0. Every output is 0, including gnt, resp_*, div_start, div_dvd, div_dsr and busy.
- State machine:
  - IDLE: if any req bit is set, the winner is the first set bit searching upward from rr_ptr, wrapping modulo NREQ. In that cycle:
    - gnt[winner] pulses for one cycle;
    - the winner's dvd/dsr slices and ID are latched into internal registers;
    - next state is DZ if the latched dsr==0, otherwise ISSUE.
  - If no req bit is set, stay in IDLE.
  - ISSUE: div_start=1 for exactly one cycle; counter cleared; next state WAIT.
  - WAIT: counter increments each cycle.
    - div_done=1: capture div_q/div_r, go to RESP.
    - Counter reaches TIMEOUT with no div_done: go to RESP with to=1 and q=r=0.
    - div_done and the timeout in the same cycle: done wins, to=0.
  - DZ: q={W{1'b1}}, r=latched dvd, dz=1; go to RESP. The core is never started.
  - RESP: resp_valid=1 for one cycle with resp_id, q, r, dz, to. rr_ptr <= (owner+1) mod NREQ. Next state IDLE.
- Operand stability: div_dvd/div_dsr are driven from the latched registers from ISSUE through WAIT and hold their value afterward. They change only when a new request is latched.
- Response fields are registered and hold between strobes. Only resp_valid marks new data.
- Requester protocol:
  - Hold req and operands stable until gnt is seen.
  - Drop req the cycle after gnt.
  - A req still high in the cycle after gnt is treated as a new request.
- No new grant is issued while busy=1: one operation in flight, no queueing.
- div_done outside WAIT is ignored.
- Latency, with grant at cycle t:
  - divide-by-zero: resp_valid at t+2;
  - normal: div_start at t+1, resp_valid one cycle after div_done.
- Throughput: a new grant is possible in the cycle after RESP.
- Reset mid-operation: immediate return to the reset state, and the in-flight result is dropped. The core has no abort input; any late div_done is ignored because the scheduler is no longer in WAIT.
- Fairness: with every requester always asserting, grants rotate 0,1,…,NREQ-1,0,…

Decomposition:
- Package srt_div_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DZ, RESP};
  - default width constants;
  - the all-ones quotient constant used for divide-by-zero.
- Sub-module rr_arbiter (combinational pick from req and rr_ptr, returning the one-hot grant and its binary index). It is reused by other shared datapaths.
- The FSM, operand latches and timeout counter stay in srt_div_sched.

Test Plan (behavioural core model with a programmable latency):
- Single request: req[0] with dvd=74, dsr=21, core latency 5 -> gnt[0] at t, div_start at t+1, resp_valid at t+7 with id=0, q=3, r=11, dz=0, to=0.
- Contention: req[1] and req[2] both asserted (dvd=100/dsr=7, dvd=9/dsr=3), rr_ptr=0 -> id 1 served first (q=14, r=2), then id 2 (q=3, r=0). Reassert both -> id 1 is served before id 2 again, because rr_ptr=3 wraps to 0.
- Divide-by-zero: req[3] with dvd=55, dsr=0 -> div_start never asserts; resp_valid at t+2 with q=64'hFFFF_FFFF_FFFF_FFFF, r=55, dz=1.
- Timeout: TIMEOUT=15, core never signals done -> resp_valid with to=1, q=r=0; the next request is then served normally.
- Reset during WAIT: RST at the third WAIT cycle -> next cycle busy=0, all outputs 0. A core div_done two cycles later produces no resp_valid.
- Spurious done: div_done pulsed in IDLE -> no resp_valid, no state change.
